// File: rtl/ps2_scan_ctrl_pkg.sv
// Shared constants and types for the PS/2 scan-code set 2 sequencing controller.
package ps2_scan_ctrl_pkg;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_BAT    = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_RESEND = 8'hFE;
  localparam logic [7:0] SC_ERR0   = 8'h00;
  localparam logic [7:0] SC_ERR1   = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GOT_E0,
    ST_GOT_F0,
    ST_GOT_E0F0
  } parse_state_e;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_evt_t;

  localparam int EVT_W = $bits(key_evt_t);

  // Keyboard status/handshake bytes that never denote a key when seen outside a prefix.
  function automatic logic is_filtered(input logic [7:0] b);
    return (b == SC_ERR0) || (b == SC_ERR1) || (b == SC_BAT) ||
           (b == SC_ACK)  || (b == SC_RESEND);
  endfunction

endpackage

// File: rtl/ps2_scan_ctrl_fifo.sv
// First-word fall-through FIFO for key events; the head output holds its last
// value once the FIFO drains.
module key_event_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 10,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  output logic [W-1:0]  data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  last_q;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      last_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
      if (!empty_o) last_q <= mem[rd_q];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= data_i;
  end

  assign data_o = empty_o ? last_q : mem[rd_q];

endmodule

// File: rtl/ps2_scan_ctrl.sv
// Parses PS/2 set-2 prefix sequences into key events and queues them behind a
// valid/ready handshake, throttling the receiver while the queue is full.
module ps2_scan_ctrl
  import ps2_scan_ctrl_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  output logic       rx_en,
  output logic       key_valid,
  input  logic       key_ready,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       overflow,
  output logic       proto_err
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;

  parse_state_e  state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          rx_en_q, overflow_q, perr_q;
  logic          timeout, emit, perr;
  key_evt_t      evt, head;
  logic          full, empty, do_pop, do_push;
  logic [CW-1:0] count, count_next;

  assign timeout = (state_q != ST_IDLE) && (tmo_q == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      tmo_q      <= '0;
      rx_en_q    <= 1'b0;
      overflow_q <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      rx_en_q    <= enable & (count_next != CW'(DEPTH));
      overflow_q <= emit & full & ~do_pop;
      perr_q     <= perr;
    end
  end

  // A byte on the timeout cycle wins, so the counter is only consulted without a tick.
  always_comb begin
    state_d = state_q;
    tmo_d   = '0;
    if (rx_done_tick) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_data == SC_EXT)      state_d = ST_GOT_E0;
          else if (rx_data == SC_BRK) state_d = ST_GOT_F0;
        end
        ST_GOT_E0: state_d = (rx_data == SC_BRK) ? ST_GOT_E0F0 : ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end else if (timeout) begin
      state_d = ST_IDLE;
    end else if (state_q != ST_IDLE) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  always_comb begin
    emit = 1'b0;
    perr = 1'b0;
    evt  = '{ext: 1'b0, brk: 1'b0, code: rx_data};
    if (rx_done_tick) begin
      case (state_q)
        ST_IDLE: emit = (rx_data != SC_EXT) && (rx_data != SC_BRK) && !is_filtered(rx_data);
        ST_GOT_E0: begin
          evt.ext = 1'b1;
          perr    = (rx_data == SC_EXT);
          emit    = (rx_data != SC_EXT) && (rx_data != SC_BRK);
        end
        ST_GOT_F0: begin
          evt.brk = 1'b1;
          perr    = (rx_data == SC_EXT) || (rx_data == SC_BRK);
          emit    = ~perr;
        end
        default: begin
          evt.ext = 1'b1;
          evt.brk = 1'b1;
          perr    = (rx_data == SC_EXT) || (rx_data == SC_BRK);
          emit    = ~perr;
        end
      endcase
    end else begin
      perr = timeout;
    end
  end

  assign do_pop     = key_ready & ~empty;
  assign do_push    = emit & (~full | do_pop);
  assign count_next = count + CW'(do_push) - CW'(do_pop);

  key_event_fifo #(.DEPTH(DEPTH), .W(EVT_W)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (emit),
    .data_i  (evt),
    .pop_i   (key_ready),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign rx_en     = rx_en_q;
  assign key_valid = ~empty;
  assign key_code  = head.code;
  assign key_ext   = head.ext;
  assign key_break = head.brk;
  assign overflow  = overflow_q;
  assign proto_err = perr_q;

endmodule

// File: tb/tb_ps2_scan_ctrl.sv
// Directed bench for ps2_scan_ctrl with a short prefix timeout.
module tb_ps2_scan_ctrl;
  localparam int DEPTH = 4;
  localparam int TMO   = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       rx_done_tick = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       key_ready = 1'b0;
  logic       rx_en, key_valid, key_ext, key_break, overflow, proto_err;
  logic [7:0] key_code;

  int total = 0;
  int pass_cnt = 0;
  int fail_cnt = 0;
  int perr_seen;

  ps2_scan_ctrl #(.DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .rx_done_tick (rx_done_tick),
    .rx_data      (rx_data),
    .rx_en        (rx_en),
    .key_valid    (key_valid),
    .key_ready    (key_ready),
    .key_code     (key_code),
    .key_ext      (key_ext),
    .key_break    (key_break),
    .overflow     (overflow),
    .proto_err    (proto_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_done_tick = 1'b1;
    rx_data      = b;
    step();
    rx_done_tick = 1'b0;
    rx_data      = 8'h00;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_evt(input string tag, input logic [7:0] code, input logic ext, input logic brk);
    chk({tag, "_valid"}, 32'(key_valid), 32'd1);
    chk({tag, "_code"},  32'(key_code),  32'(code));
    chk({tag, "_ext"},   32'(key_ext),   32'(ext));
    chk({tag, "_brk"},   32'(key_break), 32'(brk));
  endtask

  task automatic chk_idle_out(input string tag);
    chk({tag, "_valid"}, 32'(key_valid), 32'd0);
    chk({tag, "_code"},  32'(key_code),  32'd0);
    chk({tag, "_ext"},   32'(key_ext),   32'd0);
    chk({tag, "_brk"},   32'(key_break), 32'd0);
    chk({tag, "_ovf"},   32'(overflow),  32'd0);
    chk({tag, "_perr"},  32'(proto_err), 32'd0);
    chk({tag, "_rxen"},  32'(rx_en),     32'd0);
  endtask

  initial begin
    logic [7:0] drain_exp [4];
    drain_exp[0] = 8'h15; drain_exp[1] = 8'h1D; drain_exp[2] = 8'h24; drain_exp[3] = 8'h2D;

    // Reset state
    enable = 1'b1;
    step(); step(); step();
    chk_idle_out("rst");
    reset = 1'b1;
    step();
    chk("rxen_after_rst", 32'(rx_en), 32'd1);

    // Make key
    key_ready = 1'b1;
    send(8'h1C);
    chk_evt("make", 8'h1C, 1'b0, 1'b0);
    chk("make_perr", 32'(proto_err), 32'd0);
    step();
    chk("make_valid_gone", 32'(key_valid), 32'd0);

    // Extended break
    send(8'hE0);
    chk("e0_noevt", 32'(key_valid), 32'd0);
    send(8'hF0);
    chk("e0f0_noevt", 32'(key_valid), 32'd0);
    send(8'h75);
    chk_evt("extbrk", 8'h75, 1'b1, 1'b1);
    step();
    chk("extbrk_gone", 32'(key_valid), 32'd0);

    // Backpressure and overflow
    key_ready = 1'b0;
    send(8'h15);
    chk("bp_rxen1", 32'(rx_en), 32'd1);
    send(8'h1D);
    send(8'h24);
    chk("bp_rxen3", 32'(rx_en), 32'd1);
    send(8'h2D);
    chk("bp_rxen_low", 32'(rx_en), 32'd0);
    send(8'h2C);
    chk("bp_overflow", 32'(overflow), 32'd1);
    chk("bp_head_held", 32'(key_code), 32'h15);
    step();
    chk("bp_overflow_pulse", 32'(overflow), 32'd0);
    key_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d_valid", i), 32'(key_valid), 32'd1);
      chk($sformatf("drain%0d_code", i), 32'(key_code), 32'(drain_exp[i]));
      step();
      if (i == 0) chk("drain_rxen_back", 32'(rx_en), 32'd1);
    end
    chk("drain_empty", 32'(key_valid), 32'd0);

    // Prefix timeout
    send(8'hF0);
    perr_seen = 0;
    for (int i = 0; i < 2 * TMO; i++) begin
      if (proto_err === 1'b1) perr_seen++;
      step();
    end
    chk("tmo_perr_once", 32'(perr_seen), 32'd1);
    chk("tmo_noevt", 32'(key_valid), 32'd0);
    send(8'h1C);
    chk_evt("after_tmo", 8'h1C, 1'b0, 1'b0);
    step();

    // Illegal prefix and filtered bytes
    send(8'hF0);
    send(8'hF0);
    chk("f0f0_perr", 32'(proto_err), 32'd1);
    chk("f0f0_noevt", 32'(key_valid), 32'd0);
    step();
    chk("f0f0_perr_pulse", 32'(proto_err), 32'd0);
    send(8'hAA);
    send(8'hFA);
    chk("filt_noevt", 32'(key_valid), 32'd0);
    chk("filt_noerr", 32'(proto_err), 32'd0);

    // Reset mid-sequence
    send(8'hE0);
    reset = 1'b0;
    step();
    chk_idle_out("midrst");
    reset = 1'b1;
    send(8'h74);
    chk_evt("after_midrst", 8'h74, 1'b0, 1'b0);
    step();

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/ps2_scan_ctrl.md
Name: ps2_scan_ctrl

Overview:
- Sequencing controller placed between the PS/2 keyboard receiver and downstream consumers.
- Drives the receiver's rx_en and consumes its rx_done_tick/byte stream.
- Parses scan-code set 2 prefix sequences (E0 extended, F0 break) into single key events.
- Buffers key events in a small first-word-fall-through FIFO with a valid/ready output handshake; rx_en is withheld while the FIFO is full.

Parameters:
- DEPTH, 4, number of key-event entries in the output FIFO (power of 2, >= 2).
- TIMEOUT_CYC, 100000, clk cycles allowed between a prefix byte and its follow-on byte before the parser abandons the sequence.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset.
- enable  input  1  software enable; 0 forces rx_en low.
- rx_done_tick  input  1  one-cycle strobe from the receiver: rx_data holds a new byte.
- rx_data  input  8  received byte; valid only when rx_done_tick=1.
- rx_en  output  1  receive enable to the PS/2 receiver.
- key_valid  output  1  FIFO head holds an event.
- key_ready  input  1  consumer accepts the head event when key_valid&key_ready.
- key_code  output  8  scan code of the head event.
- key_ext  output  1  head event was E0-prefixed.
- key_break  output  1  head event is a release (F0-prefixed).
- overflow  output  1  one-cycle pulse: a completed event was dropped because the FIFO was full.
- proto_err  output  1  one-cycle pulse: illegal prefix sequence or prefix timeout.

Behaviour:
- Reset (reset=0 at a clk edge):
  - Parser goes to IDLE; FIFO is emptied; timeout counter is cleared.
  - key_valid=0, key_code=0, key_ext=0, key_break=0, overflow=0, proto_err=0, rx_en=0.
  - Reset mid-sequence discards any partial prefix.
- rx_en is registered: rx_en <= enable & ~full_next, where full_next is the FIFO count after the current cycle's push/pop equals DEPTH.
- Bytes only affect the parser on cycles where rx_done_tick=1. A byte that arrives while rx_en=0 (receiver finishing a frame) is still parsed.
- Parser states and transitions, byte b:
  - IDLE:
    - b=E0 -> GOT_E0.
    - b=F0 -> GOT_F0.
    - b in {00, FF, AA, FA, FE} -> dropped; stays IDLE; no event, no error.
    - Otherwise -> emit {code=b, ext=0, brk=0}; stays IDLE.
  - GOT_E0:
    - b=F0 -> GOT_E0F0.
    - b=E0 -> proto_err pulse; IDLE.
    - Otherwise -> emit {b, ext=1, brk=0}; IDLE.
  - GOT_F0:
    - b=E0 or b=F0 -> proto_err pulse; IDLE.
    - Otherwise -> emit {b, ext=0, brk=1}; IDLE.
  - GOT_E0F0:
    - b=E0 or b=F0 -> proto_err pulse; IDLE.
    - Otherwise -> emit {b, ext=1, brk=1}; IDLE.
- Timeout:
  - The counter resets on every rx_done_tick and increments each cycle while in a non-IDLE state.
  - On reaching TIMEOUT_CYC-1 without a byte: proto_err pulse, return to IDLE, no event.
  - A byte arriving on the same cycle as the timeout takes priority; it is parsed normally and no timeout is flagged.
- Emit timing: an event is written into the FIFO on the clock edge that samples rx_done_tick. key_valid rises on the next cycle (1-cycle latency from byte strobe to key_valid when the FIFO was empty).
- FIFO:
  - First-word fall-through: key_code/ext/break present the head whenever key_valid=1 and hold stable until popped.
  - Pop when key_valid & key_ready.
  - Push with FIFO not full: accepted.
  - Push with FIFO full and pop in the same cycle: accepted; count unchanged.
  - Push with FIFO full and no pop: event dropped, overflow pulses 1 cycle, FIFO contents unchanged.
  - Pointers wrap modulo DEPTH; count width is $clog2(DEPTH)+1.
  - When the FIFO empties, key_code/ext/break hold their last value; consumers ignore them while key_valid=0.
- enable=0 does not flush the FIFO or parser. It only drops rx_en (one cycle later); in-flight bytes are still parsed.

Decomposition:
- Shared package holds:
  - Byte constants SC_EXT=8'hE0, SC_BRK=8'hF0, SC_BAT=8'hAA, SC_ACK=8'hFA, SC_RESEND=8'hFE, SC_ERR0=8'h00, SC_ERR1=8'hFF.
  - Parser state encoding (IDLE, GOT_E0, GOT_F0, GOT_E0F0).
  - The 10-bit key-event record layout {ext, brk, code}.
- One sub-module: key_event_fifo (parameterised FWFT FIFO, width 10, depth DEPTH, with full/empty/count).

Test Plan:
- Make key: bytes 1C, key_ready=1 -> one event {1C,0,0}; key_valid high exactly 1 cycle, 1 cycle after the tick; no errors.
- Extended break: bytes E0, F0, 75 -> exactly one event {75, ext=1, brk=1}; prefixes produce no events.
- Backpressure: key_ready=0, five make codes 15,1D,24,2D,2C with DEPTH=4 -> rx_en falls 1 cycle after the 4th push. The 5th byte (2C) pulses overflow. Draining then yields 15,1D,24,2D in order, and rx_en returns high.
- Timeout: byte F0 then 100000 idle cycles -> proto_err pulses once; a following 1C emits {1C,0,0}, not a break.
- Illegal/filtered: F0, F0 -> proto_err pulse, no event. Bytes AA, FA -> no event, no error.
- Reset mid-sequence: E0, then reset low 1 cycle, then 74 -> event {74, ext=0, brk=0}; FIFO empty and all outputs 0 right after reset.
